// File: rtl/data_memory_pipe_if.sv
// Request/response bundle for the MEM-stage data memory.
// The master side issues requests and the slave side returns in-order responses.
interface data_memory_pipe_if #(
   parameter int unsigned ADDR_WIDTH = 32
) ();
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic [1:0]            req_maskmode;
   logic                  req_unsigned;
   logic                  resp_valid;
   logic [31:0]           resp_rdata;
   logic                  resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_maskmode, req_unsigned,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_maskmode, req_unsigned,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_memory_pipe.sv
// Byte-lane data memory with clear sweep after reset and a fixed-latency in-order response pipe.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of force-aligning them.
module data_memory_pipe #(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned MEM_ADDR_SIZE = 8,
   parameter int unsigned READ_LATENCY  = 1
) (
   input logic               clk,
   input logic               reset,
   data_memory_pipe_if.slave bus
);
   localparam int unsigned DEPTH = 1 << MEM_ADDR_SIZE;
   localparam int unsigned IW    = MEM_ADDR_SIZE;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   clear_idx;
   logic            ready_d;
   logic            clear_en_c;

   logic [31:0]     mem [DEPTH];

   logic            accept_c;
   logic [IW-1:0]   word_idx_c;
   logic [1:0]      off_c;
   logic            err_c;
   logic [3:0]      be_c;
   logic [31:0]     wlanes_c;
   logic [31:0]     rd_word_c;
   logic [7:0]      rd_byte_c;
   logic [15:0]     rd_half_c;
   logic [31:0]     load_c;
   logic [31:0]     resp_data_c;

   logic [READ_LATENCY-1:0] pipe_v;
   logic [READ_LATENCY-1:0] pipe_e;
   logic [31:0]             pipe_d [READ_LATENCY];

   // Address bits above the word index wrap by design.
   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.req_addr[ADDR_WIDTH-1:MEM_ADDR_SIZE+2];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= CLEAR;
      else       state <= state_nxt;
   end

   // Next state: leave CLEAR once the last word has been written
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (&clear_idx) state_nxt = READY;
         READY:   state_nxt = READY;
         default: state_nxt = CLEAR;
      endcase
   end

   // FSM outputs
   always_comb begin
      ready_d    = 1'b0;
      clear_en_c = 1'b0;
      case (state)
         CLEAR:   clear_en_c = 1'b1;
         default: clear_en_c = 1'b0;
      endcase
      ready_d = (state_nxt == READY);
   end

   // Registered ready and sweep index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.req_ready <= 1'b0;
         clear_idx     <= '0;
      end else begin
         bus.req_ready <= ready_d;
         clear_idx     <= clear_en_c ? clear_idx + IW'(1) : '0;
      end
   end

   // Request decode: lane enables, replicated store data, error
   always_comb begin
      accept_c   = bus.req_valid & bus.req_ready;
      word_idx_c = bus.req_addr[MEM_ADDR_SIZE+1:2];
      off_c      = bus.req_addr[1:0];
      err_c      = (bus.req_maskmode == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
      err_c      = err_c
                 | ((bus.req_maskmode == 2'b01) & off_c[0])
                 | ((bus.req_maskmode == 2'b10) & (off_c != 2'b00));
`endif
      be_c     = 4'b0000;
      wlanes_c = bus.req_wdata;
      case (bus.req_maskmode)
         2'b00: begin
            be_c     = 4'b0001 << off_c;
            wlanes_c = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            be_c     = off_c[1] ? 4'b1100 : 4'b0011;
            wlanes_c = {2{bus.req_wdata[15:0]}};
         end
         2'b10:   be_c = 4'b1111;
         default: be_c = 4'b0000;
      endcase
   end

   // Load extraction from the word as it stands at the accept edge
   always_comb begin
      rd_word_c = mem[word_idx_c];
      rd_byte_c = 8'(rd_word_c >> {off_c, 3'b000});
      rd_half_c = 16'(rd_word_c >> {off_c[1], 4'b0000});
      load_c    = '0;
      case (bus.req_maskmode)
         2'b00:   load_c = bus.req_unsigned ? {24'b0, rd_byte_c}
                                            : {{24{rd_byte_c[7]}}, rd_byte_c};
         2'b01:   load_c = bus.req_unsigned ? {16'b0, rd_half_c}
                                            : {{16{rd_half_c[15]}}, rd_half_c};
         2'b10:   load_c = rd_word_c;
         default: load_c = '0;
      endcase
      resp_data_c = (bus.req_write | err_c) ? '0 : load_c;
   end

   // Array: clear sweep has priority; ready is low throughout CLEAR anyway
   always_ff @(posedge clk) begin
      if (clear_en_c) begin
         mem[clear_idx] <= '0;
      end else if (accept_c & bus.req_write & ~err_c) begin
         for (int b = 0; b < 4; b++) begin
            if (be_c[b]) mem[word_idx_c][8*b +: 8] <= wlanes_c[8*b +: 8];
         end
      end
   end

   // In-order response shift register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_v <= '0;
         pipe_e <= '0;
         for (int i = 0; i < int'(READ_LATENCY); i++) pipe_d[i] <= '0;
      end else begin
         pipe_v[0] <= accept_c;
         pipe_e[0] <= accept_c & err_c;
         pipe_d[0] <= accept_c ? resp_data_c : '0;
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_e[i] <= pipe_e[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   assign bus.resp_valid = pipe_v[READ_LATENCY-1];
   assign bus.resp_err   = pipe_e[READ_LATENCY-1];
   assign bus.resp_rdata = pipe_d[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory_pipe.sv
// Scoreboard bench for data_memory_pipe: a byte-array reference model predicts each response,
// and a negedge monitor checks data, error flag and arrival cycle in order.
module tb_data_memory_pipe;
   localparam int unsigned AW    = 32;
   localparam int unsigned MS    = 6;
   localparam int unsigned LAT   = 3;
   localparam int unsigned DEPTH = 1 << MS;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   data_memory_pipe_if #(.ADDR_WIDTH(AW)) bus ();

   data_memory_pipe #(
      .ADDR_WIDTH(AW), .MEM_ADDR_SIZE(MS), .READ_LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int unsigned cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  ref_mem [DEPTH*4];
   int unsigned cyc = 0;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic flag(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference: memory as a flat byte array, access = run of 1/2/4 bytes.
   function automatic exp_t model_apply(input bit w, input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] m, input bit u);
      exp_t        e;
      int unsigned base  = int'(a[MS+1:2]) * 4;
      int unsigned off   = int'(a[1:0]);
      int unsigned nb    = (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
      int unsigned first = (m == 2'd0) ? off : (m == 2'd1) ? (off / 2) * 2 : 0;
      logic [31:0] ones  = 32'hFFFF_FFFF;
      logic [31:0] v     = 32'h0;
      bit          err   = (m == 2'd3);
      if (TRAP && ((m == 2'd1 && off % 2 != 0) || (m == 2'd2 && off != 0))) err = 1'b1;
      e.err = err;
      e.data = 32'h0;
      e.cyc = 0;
      if (err) return e;
      if (w) begin
         for (int k = 0; k < int'(nb); k++) ref_mem[base + first + k] = d[8*k +: 8];
      end else begin
         for (int k = 0; k < int'(nb); k++) v = v | (32'(ref_mem[base + first + k]) << (8*k));
         if (!u && nb < 4 && v[8*nb-1]) v = v | (ones << (8*nb));
         e.data = v;
      end
      return e;
   endfunction

   // Monitor: every response must match the oldest outstanding expectation, on time.
   always @(negedge clk) begin
      exp_t e;
      if (bus.resp_valid) begin
         if (exp_q.size() == 0) begin
            flag("unexpected_resp_valid");
         end else begin
            e = exp_q.pop_front();
            check("resp_cycle", 32'(cyc), 32'(e.cyc));
            check("resp_rdata", bus.resp_rdata, e.data);
            check("resp_err", 32'(bus.resp_err), 32'(e.err));
         end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         flag($sformatf("missing_resp expected at cycle %0d, now %0d", e.cyc, cyc));
      end
   end

   // Called at posedge+1; leaves req_valid asserted so calls can go back-to-back.
   task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] m, input bit u,
                        input bit use_k = 1'b0, input logic [31:0] k_data = 0, input bit k_err = 0);
      exp_t        e;
      int unsigned n = 0;
      int unsigned t;
      bus.req_valid    = 1'b1;
      bus.req_write    = w;
      bus.req_addr     = a;
      bus.req_wdata    = d;
      bus.req_maskmode = m;
      bus.req_unsigned = u;
      while (!bus.req_ready) begin
         if (n >= 4 * DEPTH) begin
            flag("req_ready_timeout");
            bus.req_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
         n++;
      end
      t = cyc;
      @(posedge clk); #1;
      e = model_apply(w, a, d, m, u);
      if (use_k) begin
         e.data = k_data;
         e.err  = k_err;
      end
      e.cyc = t + LAT;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      bus.req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Reset, check quiet outputs, then measure the clear sweep with a load held pending.
   task automatic do_reset(input logic [31:0] probe);
      int unsigned n = 0;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      exp_q.delete();
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      check("rst_resp_rdata", bus.resp_rdata, 32'h0);
      check("rst_resp_err", 32'(bus.resp_err), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid    = 1'b1;
      bus.req_write    = 1'b0;
      bus.req_addr     = probe;
      bus.req_maskmode = 2'b10;
      bus.req_unsigned = 1'b0;
      reset            = 1'b0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.req_ready && n < 4 * DEPTH);
      check("clear_ready_low_cycles", 32'(n), 32'(DEPTH));
      for (int i = 0; i < int'(DEPTH * 4); i++) ref_mem[i] = 8'h00;
      issue(1'b0, probe, 32'h0, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [1:0]  m;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      bus.req_maskmode = 2'b10;
      bus.req_unsigned = 1'b0;
      @(posedge clk); #1;
      do_reset($urandom);

      // Byte store into a word, signed/unsigned byte loads
      issue(1'b1, 32'h10, 32'h11223344, 2'b10, 1'b0);
      issue(1'b1, 32'h12, 32'h000000AA, 2'b00, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b1, 32'h11AA3344, 1'b0);
      issue(1'b0, 32'h12, 32'h0, 2'b00, 1'b1, 1'b1, 32'h000000AA, 1'b0);
      issue(1'b0, 32'h12, 32'h0, 2'b00, 1'b0, 1'b1, 32'hFFFFFFAA, 1'b0);

      // Upper half store, half/word loads
      issue(1'b1, 32'h22, 32'h00008001, 2'b01, 1'b0);
      issue(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 1'b1, 32'hFFFF8001, 1'b0);
      issue(1'b0, 32'h22, 32'h0, 2'b01, 1'b1, 1'b1, 32'h00008001, 1'b0);
      issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b1, 32'h80010000, 1'b0);
      idle(2);

      // Back-to-back loads after idle: arrival cycles +LAT, +LAT+1, +LAT+2
      issue(1'b1, 32'h0, 32'hA0A0A0A0, 2'b10, 1'b0);
      issue(1'b1, 32'h4, 32'hB1B1B1B1, 2'b10, 1'b0);
      issue(1'b1, 32'h8, 32'hC2C2C2C2, 2'b10, 1'b0);
      idle(LAT + 1);
      issue(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b1, 32'hA0A0A0A0, 1'b0);
      issue(1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 1'b1, 32'hB1B1B1B1, 1'b0);
      issue(1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 1'b1, 32'hC2C2C2C2, 1'b0);
      idle(1);

      // Misaligned word access and illegal mode
      issue(1'b1, 32'h4, 32'hCAFEF00D, 2'b10, 1'b0);
      issue(1'b0, 32'h6, 32'h0, 2'b10, 1'b0, 1'b1, TRAP ? 32'h0 : 32'hCAFEF00D, TRAP);
      issue(1'b1, 32'h6, 32'h12345678, 2'b10, 1'b0, 1'b1, 32'h0, TRAP);
      issue(1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 1'b1, TRAP ? 32'hCAFEF00D : 32'h12345678, 1'b0);
      issue(1'b1, 32'h4, 32'hFFFFFFFF, 2'b11, 1'b0, 1'b1, 32'h0, 1'b1);
      issue(1'b0, 32'h4, 32'h0, 2'b11, 1'b0, 1'b1, 32'h0, 1'b1);
      issue(1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 1'b1, TRAP ? 32'hCAFEF00D : 32'h12345678, 1'b0);
      // Address wrap: high bits ignored
      issue(1'b0, 32'hFFFF_FF04 & ~(32'(DEPTH * 4 - 1) & 32'hFFFF_FFF8), 32'h0, 2'b10, 1'b0);
      idle(LAT + 2);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[31:MS+2] = '0;
         m = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         issue(1'($urandom), a, $urandom, m, 1'($urandom));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end

      // Reset with loads in flight: those responses must never appear
      issue(1'b1, 32'h30, 32'h5A5A5A5A, 2'b10, 1'b0);
      issue(1'b0, 32'h30, 32'h0, 2'b10, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
      do_reset(32'h30);
      issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0);

      idle(LAT + 3);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
